// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared state encoding, opcode/ALU codes and strobe bundle
//               for the hardwired control sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_ST   = 5'd1;
    localparam logic [4:0] OP_ADDI = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_MUL  = 5'd7;
    localparam logic [4:0] OP_BRZR = 5'd8;
    localparam logic [4:0] OP_NOP  = 5'd9;
    localparam logic [4:0] OP_HALT = 5'd31;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd4;

    // Instructions that share a micro-sequence are grouped into one class.
    typedef enum logic [2:0] {
        CLS_REG  = 3'd0,
        CLS_ADDI = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_MUL  = 3'd4,
        CLS_BRZR = 3'd5,
        CLS_NOP  = 3'd6,
        CLS_HALT = 3'd7
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic z_hi_out;
        logic z_lo_out;
        logic hi_in;
        logic lo_in;
        logic c_out;
        logic con_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic mem_read;
        logic mem_write;
    } strobes_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_LD:                          cls = CLS_LD;
            OP_ST:                          cls = CLS_ST;
            OP_ADDI:                        cls = CLS_ADDI;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  cls = CLS_REG;
            OP_MUL:                         cls = CLS_MUL;
            OP_BRZR:                        cls = CLS_BRZR;
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] reg_alu_code(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational decode of sequencer state + latched opcode
//               into datapath, register-select and memory strobes.
// Revision    : 1.0  initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       first_cycle,
    input  logic       mem_ack,
    input  logic       con,
    output strobes_t   strobes,
    output logic [3:0] alu_op,
    output logic       run
);

    op_class_t w_cls;

    assign w_cls = op_class(opcode);

    always_comb begin
        strobes = '0;
        alu_op  = ALU_ADD;
        run     = (state != ST_RST) && (state != ST_HALT);

        case (state)
            ST_T0: begin
                strobes.pc_out = 1'b1;
                strobes.mar_in = 1'b1;
                strobes.inc_pc = 1'b1;
                strobes.z_in   = 1'b1;
            end
            ST_T1: begin
                // PC reload happens once; later wait cycles only hold the read.
                strobes.z_lo_out = 1'b1;
                strobes.pc_in    = first_cycle;
                strobes.mem_read = 1'b1;
                strobes.mdr_in   = 1'b1;
            end
            ST_T2: begin
                strobes.mdr_out = 1'b1;
                strobes.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_REG, CLS_ADDI: begin
                        strobes.grb   = 1'b1;
                        strobes.r_out = 1'b1;
                        strobes.y_in  = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        strobes.grb    = 1'b1;
                        strobes.ba_out = 1'b1;
                        strobes.y_in   = 1'b1;
                    end
                    CLS_MUL: begin
                        strobes.gra   = 1'b1;
                        strobes.r_out = 1'b1;
                        strobes.y_in  = 1'b1;
                    end
                    CLS_BRZR: begin
                        strobes.gra    = 1'b1;
                        strobes.r_out  = 1'b1;
                        strobes.con_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_cls)
                    CLS_REG: begin
                        strobes.grc   = 1'b1;
                        strobes.r_out = 1'b1;
                        strobes.z_in  = 1'b1;
                        alu_op        = reg_alu_code(opcode);
                    end
                    CLS_ADDI, CLS_LD, CLS_ST: begin
                        strobes.c_out = 1'b1;
                        strobes.z_in  = 1'b1;
                    end
                    CLS_MUL: begin
                        strobes.grb   = 1'b1;
                        strobes.r_out = 1'b1;
                        strobes.z_in  = 1'b1;
                        alu_op        = ALU_MUL;
                    end
                    CLS_BRZR: begin
                        strobes.pc_out = 1'b1;
                        strobes.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_cls)
                    CLS_REG, CLS_ADDI: begin
                        strobes.z_lo_out = 1'b1;
                        strobes.gra      = 1'b1;
                        strobes.r_in     = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        strobes.z_lo_out = 1'b1;
                        strobes.mar_in   = 1'b1;
                    end
                    CLS_MUL: begin
                        strobes.z_lo_out = 1'b1;
                        strobes.lo_in    = 1'b1;
                    end
                    CLS_BRZR: begin
                        strobes.c_out = 1'b1;
                        strobes.z_in  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (w_cls)
                    CLS_LD: begin
                        // Write-back rides on the acknowledging cycle itself.
                        strobes.mem_read = 1'b1;
                        strobes.mdr_in   = 1'b1;
                        strobes.mdr_out  = mem_ack;
                        strobes.gra      = mem_ack;
                        strobes.r_in     = mem_ack;
                    end
                    CLS_ST: begin
                        strobes.gra       = first_cycle;
                        strobes.r_out     = first_cycle;
                        strobes.mdr_in    = first_cycle;
                        strobes.mem_write = !first_cycle;
                    end
                    CLS_MUL: begin
                        strobes.z_hi_out = 1'b1;
                        strobes.hi_in    = 1'b1;
                    end
                    CLS_BRZR: begin
                        strobes.z_lo_out = 1'b1;
                        strobes.pc_in    = con;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired CPU control step sequencer; state register and
//               transitions here, strobe decode in ctrl_decode.
// Revision    : 1.0  initial release
// ============================================================================
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        mem_ack,
    input  logic        stop,
    output logic        pc_out,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        z_hi_out,
    output logic        z_lo_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic        c_out,
    output logic        con_in,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        ba_out,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic [3:0]  state
);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_opcode;
    logic       r_first;
    op_class_t  w_cls;
    strobes_t   w_strobes;
    logic       w_unused_ir;

    assign w_cls       = op_class(r_opcode);
    assign w_unused_ir = ^ir[26:0];

    // r_first marks the first cycle spent in a step, so waits can be told apart.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state  <= ST_RST;
            r_opcode <= 5'd0;
            r_first  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
            if (r_state == ST_T2) begin
                r_opcode <= ir[31:27];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:  w_next = ST_T0;
            ST_T0:   w_next = stop ? ST_HALT : ST_T1;
            ST_T1:   w_next = mem_ack ? ST_T2 : ST_T1;
            ST_T2:   w_next = ST_T3;
            ST_T3: begin
                case (w_cls)
                    CLS_NOP:  w_next = ST_T0;
                    CLS_HALT: w_next = ST_HALT;
                    default:  w_next = ST_T4;
                endcase
            end
            ST_T4:   w_next = ST_T5;
            ST_T5:   w_next = ((w_cls == CLS_REG) || (w_cls == CLS_ADDI)) ? ST_T0 : ST_T6;
            ST_T6: begin
                case (w_cls)
                    CLS_LD:  w_next = mem_ack ? ST_T0 : ST_T6;
                    // The store request is only raised after the MDR load cycle.
                    CLS_ST:  w_next = (!r_first && mem_ack) ? ST_T0 : ST_T6;
                    default: w_next = ST_T0;
                endcase
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_RST;
        endcase
    end

    ctrl_decode u_decode (
        .state       (r_state),
        .opcode      (r_opcode),
        .first_cycle (r_first),
        .mem_ack     (mem_ack),
        .con         (con),
        .strobes     (w_strobes),
        .alu_op      (alu_op),
        .run         (run)
    );

    assign pc_out    = w_strobes.pc_out;
    assign pc_in     = w_strobes.pc_in;
    assign inc_pc    = w_strobes.inc_pc;
    assign mar_in    = w_strobes.mar_in;
    assign mdr_in    = w_strobes.mdr_in;
    assign mdr_out   = w_strobes.mdr_out;
    assign ir_in     = w_strobes.ir_in;
    assign y_in      = w_strobes.y_in;
    assign z_in      = w_strobes.z_in;
    assign z_hi_out  = w_strobes.z_hi_out;
    assign z_lo_out  = w_strobes.z_lo_out;
    assign hi_in     = w_strobes.hi_in;
    assign lo_in     = w_strobes.lo_in;
    assign c_out     = w_strobes.c_out;
    assign con_in    = w_strobes.con_in;
    assign gra       = w_strobes.gra;
    assign grb       = w_strobes.grb;
    assign grc       = w_strobes.grc;
    assign r_in      = w_strobes.r_in;
    assign r_out     = w_strobes.r_out;
    assign ba_out    = w_strobes.ba_out;
    assign mem_read  = w_strobes.mem_read;
    assign mem_write = w_strobes.mem_write;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed + randomized bench with a step/instruction-level
//               reference model of the control sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    localparam logic [22:0] PC_OUT    = 23'd1 << 0;
    localparam logic [22:0] PC_IN     = 23'd1 << 1;
    localparam logic [22:0] INC_PC    = 23'd1 << 2;
    localparam logic [22:0] MAR_IN    = 23'd1 << 3;
    localparam logic [22:0] MDR_IN    = 23'd1 << 4;
    localparam logic [22:0] MDR_OUT   = 23'd1 << 5;
    localparam logic [22:0] IR_IN     = 23'd1 << 6;
    localparam logic [22:0] Y_IN      = 23'd1 << 7;
    localparam logic [22:0] Z_IN      = 23'd1 << 8;
    localparam logic [22:0] Z_HI_OUT  = 23'd1 << 9;
    localparam logic [22:0] Z_LO_OUT  = 23'd1 << 10;
    localparam logic [22:0] HI_IN     = 23'd1 << 11;
    localparam logic [22:0] LO_IN     = 23'd1 << 12;
    localparam logic [22:0] C_OUT     = 23'd1 << 13;
    localparam logic [22:0] CON_IN    = 23'd1 << 14;
    localparam logic [22:0] GRA       = 23'd1 << 15;
    localparam logic [22:0] GRB       = 23'd1 << 16;
    localparam logic [22:0] GRC       = 23'd1 << 17;
    localparam logic [22:0] R_IN      = 23'd1 << 18;
    localparam logic [22:0] R_OUT     = 23'd1 << 19;
    localparam logic [22:0] BA_OUT    = 23'd1 << 20;
    localparam logic [22:0] MEM_READ  = 23'd1 << 21;
    localparam logic [22:0] MEM_WRITE = 23'd1 << 22;
    localparam logic [22:0] BUS_MASK  = PC_OUT | MDR_OUT | Z_LO_OUT | Z_HI_OUT | C_OUT | R_OUT;

    localparam int RSTS      = -1;
    localparam int HALTS     = 9;
    localparam int NCYC      = 4000;
    localparam int TRACE_N   = 70;
    localparam int RND_START = 66;

    typedef struct packed {
        logic [22:0] s;
        logic [3:0]  alu;
        logic        run;
        logic [3:0]  st;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        int          delay;
        bit          con;
        bit          stop;
        bit          clr;
    } entry_t;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = '0;
    logic        con = 1'b0;
    logic        mem_ack = 1'b0;
    logic        stop = 1'b0;
    logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in;
    logic        z_hi_out, z_lo_out, hi_in, lo_in, c_out, con_in;
    logic        gra, grb, grc, r_in, r_out, ba_out, mem_read, mem_write;
    logic [3:0]  alu_op;
    logic        run;
    logic [3:0]  state;
    logic [22:0] dut_s;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [3:0]  tr_state [TRACE_N];
    logic [3:0]  tr_alu   [TRACE_N];
    logic [22:0] tr_s     [TRACE_N];
    logic        tr_run   [TRACE_N];

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .con(con), .mem_ack(mem_ack), .stop(stop),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .z_hi_out(z_hi_out),
        .z_lo_out(z_lo_out), .hi_in(hi_in), .lo_in(lo_in), .c_out(c_out), .con_in(con_in),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .run(run), .state(state)
    );

    assign dut_s = {mem_write, mem_read, ba_out, r_out, r_in, grc, grb, gra, con_in, c_out,
                    lo_in, hi_in, z_lo_out, z_hi_out, z_in, y_in, ir_in, mdr_out, mdr_in,
                    mar_in, inc_pc, pc_in, pc_out};

    // 0 ld, 1 st, 2 addi, 3 register ALU, 4 mul, 5 brzr, 6 nop-like, 7 halt
    function automatic int cls(input int op);
        case (op)
            0:          return 0;
            1:          return 1;
            2:          return 2;
            3, 4, 5, 6: return 3;
            7:          return 4;
            8:          return 5;
            31:         return 7;
            default:    return 6;
        endcase
    endfunction

    // step: -1 reset, 0..6 = T0..T6, 9 halt; cnt = cycles already spent in this step
    function automatic exp_t model_out(input int step, input int op, input int cnt,
                                       input bit ack, input bit c);
        exp_t e;
        int   k = cls(op);
        e.s   = '0;
        e.alu = 4'd0;
        e.run = (step >= 0) && (step <= 6);
        e.st  = (step < 0) ? 4'd0 : (step == HALTS) ? 4'd8 : 4'(step + 1);
        case (step)
            0: e.s = PC_OUT | MAR_IN | INC_PC | Z_IN;
            1: e.s = Z_LO_OUT | MEM_READ | MDR_IN | ((cnt == 0) ? PC_IN : 23'd0);
            2: e.s = MDR_OUT | IR_IN;
            3: case (k)
                   0, 1:    e.s = GRB | BA_OUT | Y_IN;
                   2, 3:    e.s = GRB | R_OUT | Y_IN;
                   4:       e.s = GRA | R_OUT | Y_IN;
                   5:       e.s = GRA | R_OUT | CON_IN;
                   default: e.s = '0;
               endcase
            4: case (k)
                   3:       begin e.s = GRC | R_OUT | Z_IN; e.alu = 4'(op - 3); end
                   0, 1, 2: e.s = C_OUT | Z_IN;
                   4:       begin e.s = GRB | R_OUT | Z_IN; e.alu = 4'd4; end
                   5:       e.s = PC_OUT | Y_IN;
                   default: e.s = '0;
               endcase
            5: case (k)
                   2, 3:    e.s = Z_LO_OUT | GRA | R_IN;
                   0, 1:    e.s = Z_LO_OUT | MAR_IN;
                   4:       e.s = Z_LO_OUT | LO_IN;
                   5:       e.s = C_OUT | Z_IN;
                   default: e.s = '0;
               endcase
            6: case (k)
                   0:       e.s = MEM_READ | MDR_IN | (ack ? (MDR_OUT | GRA | R_IN) : 23'd0);
                   1:       e.s = (cnt == 0) ? (GRA | R_OUT | MDR_IN) : MEM_WRITE;
                   4:       e.s = Z_HI_OUT | HI_IN;
                   5:       e.s = Z_LO_OUT | (c ? PC_IN : 23'd0);
                   default: e.s = '0;
               endcase
            default: e.s = '0;
        endcase
        return e;
    endfunction

    function automatic int model_next(input int step, input int op, input int cnt,
                                      input bit ack, input bit stp);
        int k = cls(op);
        case (step)
            RSTS:  return 0;
            HALTS: return HALTS;
            0:     return stp ? HALTS : 1;
            1:     return ack ? 2 : 1;
            2:     return 3;
            3:     return (k == 6) ? 0 : (k == 7) ? HALTS : 4;
            4:     return 5;
            5:     return (k == 2 || k == 3) ? 0 : 6;
            6:     begin
                if (k == 0) return ack ? 0 : 6;
                if (k == 1) return (cnt > 0 && ack) ? 0 : 6;
                return 0;
            end
            default: return RSTS;
        endcase
    endfunction

    function automatic bit model_req(input int step, input int op, input int cnt);
        int k = cls(op);
        return (step == 1) || (step == 6 && k == 0) || (step == 6 && k == 1 && cnt > 0);
    endfunction

    function automatic entry_t rand_entry();
        entry_t en;
        int     idx = $urandom_range(0, 14);
        int     op;
        if (idx <= 9)       op = idx;
        else if (idx == 10) op = 31;
        else if (idx == 11) op = $urandom_range(10, 30);
        else                op = (idx == 12) ? 0 : (idx == 13) ? 1 : 7;
        en.ir    = {5'(op), 27'($urandom)};
        en.delay = $urandom_range(0, 3);
        en.con   = 1'($urandom);
        en.stop  = ($urandom_range(0, 19) == 0);
        en.clr   = ($urandom_range(0, 7) == 0);
        return en;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, "_strobes"}, 32'(dut_s), 32'(e.s));
        chk({tag, "_alu_op"},  32'(alu_op), 32'(e.alu));
        chk({tag, "_run"},     32'(run), 32'(e.run));
        chk({tag, "_state"},   32'(state), 32'(e.st));
        chk({tag, "_bus_onehot"}, 32'($countones(dut_s & BUS_MASK) <= 1), 32'd1);
    endtask

    task automatic lit(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        cyc = idx;
        chk(name, act, exp);
    endtask

    initial begin
        entry_t dq[$];
        entry_t cur;
        exp_t   e;
        int     m_step = RSTS;
        int     m_op = 0;
        int     m_cnt = 0;
        int     resp_cnt = 0;
        int     nxt;
        bit     req;
        bit     do_clr;
        int     add_states[8] = '{0, 1, 2, 3, 4, 5, 6, 1};

        cur = '{ir: 32'd0, delay: 0, con: 1'b0, stop: 1'b0, clr: 1'b0};
        dq.push_back('{ir: 32'h18A20000,             delay: 0, con: 1'b0, stop: 1'b0, clr: 1'b0});
        dq.push_back('{ir: {5'd0,  27'h0123456},     delay: 3, con: 1'b0, stop: 1'b0, clr: 1'b0});
        dq.push_back('{ir: {5'd7,  27'h0654321},     delay: 0, con: 1'b0, stop: 1'b0, clr: 1'b0});
        dq.push_back('{ir: {5'd8,  27'h0000100},     delay: 0, con: 1'b1, stop: 1'b0, clr: 1'b0});
        dq.push_back('{ir: {5'd8,  27'h0000200},     delay: 0, con: 1'b0, stop: 1'b0, clr: 1'b0});
        dq.push_back('{ir: {5'd1,  27'h0ABCDEF},     delay: 2, con: 1'b0, stop: 1'b0, clr: 1'b1});
        dq.push_back('{ir: {5'd9,  27'h0000000},     delay: 0, con: 1'b0, stop: 1'b1, clr: 1'b0});
        dq.push_back('{ir: {5'd31, 27'h0000000},     delay: 0, con: 1'b0, stop: 1'b0, clr: 1'b0});

        repeat (2) @(posedge clock);

        for (int k = 0; k < NCYC; k++) begin
            @(negedge clock);
            cyc   = k;
            clear = 1'b0;
            if (m_step == 0) begin
                if (dq.size() > 0) cur = dq.pop_front();
                else               cur = rand_entry();
            end
            ir   = (m_step == 2) ? cur.ir : $urandom;
            con  = (m_step == 6) ? cur.con : 1'($urandom);
            stop = (m_step == 0) ? cur.stop : 1'($urandom);
            req  = model_req(m_step, m_op, m_cnt);
            if (req) begin
                mem_ack = (resp_cnt >= cur.delay);
                resp_cnt++;
            end else begin
                mem_ack  = 1'($urandom);
                resp_cnt = 0;
            end
            #1;
            e = model_out(m_step, m_op, m_cnt, mem_ack, con);
            compare_all("cycle", e);
            if (k < TRACE_N) begin
                tr_state[k] = state;
                tr_alu[k]   = alu_op;
                tr_s[k]     = dut_s;
                tr_run[k]   = run;
            end

            do_clr = (m_step == HALTS && m_cnt == 2)
                  || (cur.clr && m_step == 6 && req && !mem_ack)
                  || (k >= RND_START && $urandom_range(0, 99) == 0);
            if (do_clr) begin
                #1 clear = 1'b1;
                #1;
                e = model_out(RSTS, 0, 0, 1'b0, 1'b0);
                compare_all("async_clear", e);
                m_step   = RSTS;
                m_cnt    = 0;
                resp_cnt = 0;
            end else begin
                nxt = model_next(m_step, m_op, m_cnt, mem_ack, stop);
                if (m_step == 2) m_op = int'(ir[31:27]);
                m_cnt  = (nxt == m_step) ? m_cnt + 1 : 0;
                m_step = nxt;
            end
        end

        // Hand-derived timeline of the directed program at the head of the run.
        for (int i = 0; i < 8; i++) lit("add_state_seq", i, 32'(tr_state[i]), 32'(add_states[i]));
        lit("add_T4_alu_op", 5, 32'(tr_alu[5]), 32'd0);
        lit("add_T5_r_in_gra", 6, 32'(tr_s[6][18] & tr_s[6][15]), 32'd1);
        for (int i = 8; i < 12; i++) lit("ld_T1_held", i, 32'(tr_state[i]), 32'd2);
        lit("ld_T1_pc_in_first", 8, 32'(tr_s[8][1]), 32'd1);
        for (int i = 9; i < 12; i++) lit("ld_T1_pc_in_wait", i, 32'(tr_s[i][1]), 32'd0);
        lit("ld_T2_after_wait", 12, 32'(tr_state[12]), 32'd3);
        for (int i = 16; i < 20; i++) lit("ld_T6_held", i, 32'(tr_state[i]), 32'd7);
        for (int i = 16; i < 19; i++) lit("ld_T6_mdr_out_wait", i, 32'(tr_s[i][5]), 32'd0);
        lit("ld_T6_mdr_out_exit", 19, 32'(tr_s[19][5]), 32'd1);
        lit("ld_T6_r_in_exit", 19, 32'(tr_s[19][18]), 32'd1);
        lit("ld_back_to_T0", 20, 32'(tr_state[20]), 32'd1);
        lit("mul_T4_state", 24, 32'(tr_state[24]), 32'd5);
        lit("mul_T4_alu_op", 24, 32'(tr_alu[24]), 32'd4);
        lit("mul_T5_lo_in", 25, 32'(tr_s[25][12]), 32'd1);
        lit("mul_T6_hi_in", 26, 32'(tr_s[26][11]), 32'd1);
        lit("brzr1_T6_state", 33, 32'(tr_state[33]), 32'd7);
        lit("brzr1_T6_pc_in", 33, 32'(tr_s[33][1]), 32'd1);
        lit("brzr0_T6_pc_in", 40, 32'(tr_s[40][1]), 32'd0);
        lit("brzr0_then_T0", 41, 32'(tr_state[41]), 32'd1);
        lit("st_T6_mem_write", 50, 32'(tr_s[50][22]), 32'd1);
        lit("st_clear_rst", 51, 32'(tr_state[51]), 32'd0);
        lit("st_clear_then_T0", 52, 32'(tr_state[52]), 32'd1);
        lit("stop_halt_state", 53, 32'(tr_state[53]), 32'd8);
        lit("stop_halt_run", 53, 32'(tr_run[53]), 32'd0);
        lit("halt_op_state", 61, 32'(tr_state[61]), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
